// File: rtl/adder_arbiter_pkg.sv
// adder_arbiter_pkg
// Shared definitions for the adder arbiter slice:
//   state_t  - controller state encoding (IDLE, ADD, DONE)
//   ADD_W    - width of the shared ripple adder
//   idx_w()  - width of a requester index for n requesters (minimum 1 bit)
package adder_arbiter_pkg;

  localparam int ADD_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/adder_arbiter_adder.sv
// adder_arbiter_adder
// Plain 8-bit ripple-carry adder built from eight one-bit full adders.
// Ports:
//   a, b  [ADD_W-1:0]  operands
//   cin                carry into bit 0
//   sum   [ADD_W-1:0]  a + b + cin, modulo 2^ADD_W
// The carry out of the top bit is never formed: the arbiter only wants the
// wrapped sum, so the chain simply stops at the last full adder.
module adder_arbiter_adder
  import adder_arbiter_pkg::*;
(
  input  logic [ADD_W-1:0] a,
  input  logic [ADD_W-1:0] b,
  input  logic             cin,
  output logic [ADD_W-1:0] sum
);

  // c[i] is the carry into bit i.
  logic [ADD_W-1:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < ADD_W; i++) begin : g_fa
    assign sum[i] = a[i] ^ b[i] ^ c[i];
    if (i < ADD_W - 1) begin : g_carry
      assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

endmodule

// File: rtl/adder_arbiter.sv
// adder_arbiter
// Round-robin arbiter in front of one shared 8-bit adder. Each requester
// holds req high with its operands until it sees its gnt pulse; the winner's
// operands are captured, added, and the wrapped sum is presented for one
// cycle with res_valid.
//
// Handshake: req[i] is a level request that is only looked at while the
// controller is idle. A request is accepted on the edge that raises gnt[i]
// (gnt is high for the cycle following that edge); operands are captured on
// that same edge, so the requester may change or drop them while gnt is high.
// There is no backpressure on the result side: res_valid is a one-cycle
// pulse and res_sum/res_id then hold until the next result replaces them.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req   [NREQ-1:0]    per-requester add request
//   op_a  [NREQ*W-1:0]  operand A, requester i at [i*W +: W]
//   op_b  [NREQ*W-1:0]  operand B, same packing
//   gnt   [NREQ-1:0]    one-hot grant pulse (operand capture)
//   res_valid           one-cycle result strobe
//   res_id              requester that owns res_sum
//   res_sum [W-1:0]     (A + B) mod 2^W
//   busy                high whenever the controller is not idle
//   dbg_state           current controller state
module adder_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = ADD_W,
  localparam int IW  = idx_w(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ*W-1:0] op_a,
  input  logic [NREQ*W-1:0] op_b,
  output logic [NREQ-1:0] gnt,
  output logic            res_valid,
  output logic [IW-1:0]   res_id,
  output logic [W-1:0]    res_sum,
  output logic            busy,
  output state_t          dbg_state
);

  state_t          state, state_n;
  logic [IW-1:0]   last_grant;
  logic [IW-1:0]   idx_q;
  logic [W-1:0]    a_q, b_q;
  logic [W-1:0]    sum;
  logic [IW-1:0]   winner;
  logic            take;

  // Round-robin pick: scan upward from the requester after the last winner,
  // wrapping around, and take the first active request. Returns 0 when
  // nothing is requested; callers only use the result when req != 0.
  function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] r,
                                            input logic [IW-1:0]   last);
    logic [IW-1:0] pick;
    logic          found;
    int            idx;
    pick  = '0;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last) + k) % NREQ;
      if (!found && r[idx]) begin
        pick  = IW'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  assign winner = rr_pick(req, last_grant);
  assign take   = (state == ST_IDLE) && (req != '0);

  adder_arbiter_adder u_adder (
    .a   (a_q),
    .b   (b_q),
    .cin (1'b0),
    .sum (sum)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next state and decoded outputs. gnt/res_valid/busy are pure decodes of
  // the registered state, so an asynchronous reset clears them immediately.
  always_comb begin
    state_n   = state;
    gnt       = '0;
    res_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (req != '0) state_n = ST_ADD;
      end
      ST_ADD: begin
        gnt[idx_q] = 1'b1;
        state_n    = ST_DONE;
      end
      ST_DONE: begin
        res_valid = 1'b1;
        state_n   = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  assign dbg_state = state;

  // Operand capture and arbitration history; updated only when a request
  // is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q        <= '0;
      b_q        <= '0;
      idx_q      <= '0;
      last_grant <= IW'(NREQ - 1);
    end else if (take) begin
      a_q        <= op_a[winner*W +: W];
      b_q        <= op_b[winner*W +: W];
      idx_q      <= winner;
      last_grant <= winner;
    end
  end

  // Result registers load at the end of ADD and otherwise hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_sum <= '0;
      res_id  <= '0;
    end else if (state == ST_ADD) begin
      res_sum <= sum;
      res_id  <= idx_q;
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter
// Self-checking bench for adder_arbiter (NREQ=4, W=8). A transaction-level
// reference tracks which requester the round-robin rule selects, what it
// will be paid back, and the three-cycle occupancy of the adder; every cycle
// the DUT outputs are compared against it, and results are matched through
// an expected queue.
module tb_adder_arbiter;
  import adder_arbiter_pkg::*;

  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int IW   = 2;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] op_a;
  logic [NREQ*W-1:0] op_b;
  logic [NREQ-1:0]   gnt;
  logic              res_valid;
  logic [IW-1:0]     res_id;
  logic [W-1:0]      res_sum;
  logic              busy;
  state_t            dbg_state;

  adder_arbiter #(.NREQ(NREQ), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .op_a      (op_a),
    .op_b      (op_b),
    .gnt       (gnt),
    .res_valid (res_valid),
    .res_id    (res_id),
    .res_sum   (res_sum),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got running want done");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [IW+W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // busy_left: cycles of adder occupancy still to run after the current
  // edge (2 right after a grant, 1 during the result cycle, 0 idle).
  int          busy_left;
  int          last;
  int          cur_id;
  logic [W-1:0] cur_sum;
  int          hold_id;
  logic [W-1:0] hold_sum;

  function automatic int rr_choose(input logic [NREQ-1:0] r, input int prev);
    int i;
    i = prev;
    repeat (NREQ) begin
      i = (i + 1) % NREQ;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    busy_left = 0;
    last      = NREQ - 1;
    cur_id    = 0;
    cur_sum   = '0;
    hold_id   = 0;
    hold_sum  = '0;
    exp_q.delete();
  endtask

  task automatic model_edge();
    int w;
    if (busy_left == 2) begin
      busy_left = 1;
      hold_id   = cur_id;
      hold_sum  = cur_sum;
    end else if (busy_left == 1) begin
      busy_left = 0;
    end else if (req != '0) begin
      w         = rr_choose(req, last);
      last      = w;
      cur_id    = w;
      cur_sum   = W'((int'(op_a[w*W +: W]) + int'(op_b[w*W +: W])) % 256);
      busy_left = 2;
      exp_q.push_back({IW'(w), cur_sum});
    end
  endtask

  // ---------------- observation ----------------
  int cyc = 0;
  bit drop_on_gnt = 0;
  int gnt_log[$];
  int gnt_cyc[$];
  int valid_cnt = 0;

  task automatic compare();
    logic [NREQ-1:0] eg;
    logic [IW+W-1:0] e;
    eg = '0;
    if (busy_left == 2) eg[cur_id] = 1'b1;
    check("gnt",       32'(gnt),       32'(eg));
    check("res_valid", 32'(res_valid), 32'(busy_left == 1));
    check("busy",      32'(busy),      32'(busy_left != 0));
    check("res_id",    32'(res_id),    32'(hold_id));
    check("res_sum",   32'(res_sum),   32'(hold_sum));
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        gnt_log.push_back(i);
        gnt_cyc.push_back(cyc);
        if (drop_on_gnt) req[i] = 1'b0;
      end
    end
    if (res_valid) begin
      valid_cnt++;
      if (exp_q.size() == 0) begin
        check("result_unexpected", 32'(res_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("sb_id",  32'(res_id),  32'(e[IW+W-1:W]));
        check("sb_sum", 32'(res_sum), 32'(e[W-1:0]));
      end
    end
  endtask

  // One clock: model follows the edge, DUT is sampled 1 time unit later,
  // then the caller may drive new inputs.
  task automatic step();
    @(posedge clk);
    cyc++;
    if (rst_n) model_edge();
    #1;
    compare();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    #1;
    compare();
    repeat (2) @(negedge clk);
    compare();
    rst_n = 1'b1;
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a,
                        input logic [W-1:0] b);
    op_a[i*W +: W] = a;
    op_b[i*W +: W] = b;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    req  = '0;
    op_a = '0;
    op_b = '0;
    model_reset();
    do_reset();
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));

    // Single request 0x12 + 0x34 on requester 0.
    set_op(0, 8'h12, 8'h34);
    req = 4'b0001;
    step();
    check("single_gnt", 32'(gnt), 32'h1);
    req = '0;
    step();
    check("single_valid", 32'(res_valid), 32'h1);
    check("single_id",    32'(res_id),    32'h0);
    check("single_sum",   32'(res_sum),   32'h46);
    step();
    check("single_hold",  32'(res_sum),   32'h46);

    // Wrap-around on requester 2.
    set_op(2, 8'hF0, 8'h20);
    req = 4'b0100;
    n = 0;
    while (!res_valid && n < 10) begin
      step();
      if (gnt != '0) req = '0;
      n++;
    end
    check("wrap_seen", 32'(res_valid), 32'h1);
    check("wrap_sum",  32'(res_sum),   32'h10);
    check("wrap_id",   32'(res_id),    32'h2);
    step();

    // Contention: all four request, each drops after its grant.
    do_reset();
    for (int i = 0; i < NREQ; i++) set_op(i, 8'(i * 16 + 1), 8'(i + 3));
    gnt_log.delete();
    gnt_cyc.delete();
    valid_cnt   = 0;
    drop_on_gnt = 1;
    req = 4'b1111;
    n = 0;
    while (valid_cnt < 4 && n < 30) begin
      step();
      n++;
    end
    drop_on_gnt = 0;
    check("cont_valids", 32'(valid_cnt), 32'd4);
    check("cont_ngnt",   32'(gnt_log.size()), 32'd4);
    if (gnt_log.size() == 4) begin
      for (int i = 0; i < 4; i++) check("cont_order", 32'(gnt_log[i]), 32'(i));
      for (int i = 1; i < 4; i++)
        check("cont_spacing", 32'(gnt_cyc[i] - gnt_cyc[i-1]), 32'd3);
    end

    // Fairness: 0 and 2 held permanently.
    step();
    gnt_log.delete();
    req = 4'b0101;
    repeat (12) step();
    req = '0;
    repeat (3) step();
    check("fair_ngnt", 32'(gnt_log.size()), 32'd4);
    if (gnt_log.size() == 4) begin
      check("fair_g0", 32'(gnt_log[0]), 32'd0);
      check("fair_g1", 32'(gnt_log[1]), 32'd2);
      check("fair_g2", 32'(gnt_log[2]), 32'd0);
      check("fair_g3", 32'(gnt_log[3]), 32'd2);
    end

    // Reset in the middle of an operation for requester 1.
    set_op(1, 8'h55, 8'h22);
    req = 4'b0010;
    step();
    check("mid_gnt", 32'(gnt), 32'h2);
    req = '0;
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("mid_rst_gnt",  32'(gnt),       32'h0);
    check("mid_rst_busy", 32'(busy),      32'h0);
    check("mid_rst_val",  32'(res_valid), 32'h0);
    check("mid_rst_sum",  32'(res_sum),   32'h0);
    check("mid_rst_id",   32'(res_id),    32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    valid_cnt = 0;
    repeat (4) step();
    check("mid_no_valid", 32'(valid_cnt), 32'd0);
    req = 4'b0010;
    step();
    check("mid_regnt", 32'(gnt), 32'h2);
    req = '0;
    step();
    check("mid_sum", 32'(res_sum), 32'h77);
    step();

    // Operand change right after capture.
    set_op(0, 8'h11, 8'h22);
    req = 4'b0001;
    n = 0;
    while (gnt == '0 && n < 6) begin
      step();
      n++;
    end
    check("stab_gnt", 32'(gnt), 32'h1);
    req = '0;
    set_op(0, 8'hFF, 8'h22);
    step();
    check("stab_sum", 32'(res_sum), 32'h33);
    step();

    // Randomized traffic.
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (req[i]) begin
          if ($urandom_range(0, 9) == 0) req[i] = 1'b0;
        end else if ($urandom_range(0, 9) < 3) begin
          req[i] = 1'b1;
          set_op(i, 8'($urandom), 8'($urandom));
        end
        if ($urandom_range(0, 9) < 2) set_op(i, 8'($urandom), 8'($urandom));
      end
      step();
      if (c == 250) begin
        #2;
        do_reset();
      end
    end
    req = '0;
    repeat (4) step();
    check("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing the adder (2..8).
REQ-002 Parameter W, default 8: operand/result width; fixed at 8 by the shared adder.
REQ-003 clk  input  1  single system clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req  input  NREQ  per-requester add request; held high with operands until granted.
REQ-006 op_a  input  NREQ*W  packed operand A, requester i at bits [i*W +: W].
REQ-007 op_b  input  NREQ*W  packed operand B, same packing.
REQ-008 gnt  output  NREQ  one-hot grant pulse, one cycle, marks operand capture.
REQ-009 res_valid  output  1  one-cycle pulse, result present.
REQ-010 res_id  output  clog2(NREQ)  index of requester owning res_sum.
REQ-011 res_sum  output  W  (A+B) mod 2^W.
REQ-012 busy  output  1  high in any state other than IDLE.

Function
REQ-013 FSM states SHALL be IDLE, ADD, DONE; encoding from shared package.
REQ-014 IDLE, req==0: remain IDLE, all outputs except res_sum/res_id low.
REQ-015 IDLE, req!=0 at edge: select winner round-robin, latch its op_a/op_b and index, drive gnt one-hot for the following cycle, go ADD.
REQ-016 Round robin: search starts at (last_grant+1) mod NREQ, increasing index with wrap; first set req bit wins.
REQ-017 last_grant SHALL update only on a grant.
REQ-018 ADD: adder inputs are latched operands, carry-in 0; at edge register sum into res_sum, index into res_id, go DONE.
REQ-019 DONE: res_valid high exactly this cycle; next edge go IDLE.
REQ-020 Latency: req sampled at edge T -> gnt high cycle T..T+1, res_valid high cycle T+1..T+2; one operation per 3 cycles max.
REQ-021 Carry out of bit W-1 SHALL be discarded (wrap-around), no overflow flag.
REQ-022 req changes while busy SHALL be ignored; no queuing; a request dropped before grant is lost silently.
REQ-023 Granted requester holding req high after gnt SHALL be re-arbitrated as a new request in the next IDLE.
REQ-024 res_sum/res_id SHALL hold their value after DONE until the next ADD completes.
REQ-025 Operand changes after capture SHALL not affect the result.

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, gnt=0, res_valid=0, busy=0, res_sum=0, res_id=0, latched operands=0, last_grant=NREQ-1 (requester 0 wins first).
REQ-027 Reset during ADD or DONE SHALL abort the operation with no res_valid pulse after release.
REQ-028 First arbitration SHALL occur at the first rising edge with rst_n high.

Structure
REQ-029 Shared package holds FSM state typedef, W constant, and the index-width function.
REQ-030 One sub-module: the existing 8-bit ripple adder instance (eight one-bit full adders), carry-in tied 0, carry-out unused.
REQ-031 Round-robin selection SHALL be a combinational function inside adder_arbiter; no further sub-modules.

Verification
REQ-032 Single request: req=0001, op_a[0]=0x12, op_b[0]=0x34 -> gnt=0001 one cycle, then res_valid, res_id=0, res_sum=0x46.
REQ-033 Wrap: op_a=0xF0, op_b=0x20 on requester 2 -> res_sum=0x10, res_id=2.
REQ-034 Contention: req=1111 held, each dropped after its gnt -> grants in order 0,1,2,3, one every 3 cycles, four res_valid pulses with matching res_id.
REQ-035 Fairness: req=0101 held permanently -> grants alternate 0,2,0,2; requesters 1,3 never granted.
REQ-036 Reset mid-op: assert rst_n low during ADD for requester 1 -> outputs zero at once, no res_valid after release; next req=0010 granted normally.
REQ-037 Operand stability: change op_a[0] the cycle after gnt -> result uses captured value.
